fetch_ctrl: RTL and testbench



---
 rtl/core_pkg.sv | 27 ++
 rtl/sat_counter.sv | 34 +++
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-side definitions: next-PC source encodings, fetch controller
// states and a PC alignment helper.
package core_pkg;

  localparam int unsigned PcWidth = 32;

  // Encoding of the next-PC mux select driven towards the datapath.
  typedef enum logic [1:0] {
    PcSrcBoot = 2'b00,
    PcSrcEpc  = 2'b01,
    PcSrcTrap = 2'b10,
    PcSrcNext = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    StBoot    = 2'b00,
    StRun     = 2'b01,
    StWait    = 2'b10,
    StExcWait = 2'b11
  } fetch_state_e;

  // Instructions are word aligned; low bits of any loaded PC are discarded.
  function automatic logic [PcWidth-1:0] align_pc(input logic [PcWidth-1:0] pc);
    return {pc[PcWidth-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, clears the count
//   inc_i   : increment request for this cycle
//   count_o : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, issues AHB-Lite fetch
// requests, selects the next-PC source and handles redirects from branches,
// traps and MRET, including misaligned branch targets.
//   clk_in              : clock
//   rst_in              : asynchronous active-high reset
//   ahb_ready_in        : HREADY of the instruction bus
//   stall_in            : decode hazard stall, holds the PC
//   branch_taken_in     : execute-stage branch/jump taken
//   misaligned_instr_in : taken-branch target has bit 1 set
//   trap_taken_in       : trap entry committed
//   mret_in             : MRET committed
//   pc_mux_in           : next-PC value chosen by pc_src_out
//   pc_src_out          : next-PC select (boot / epc / trap vector / next)
//   pc_out              : current fetch PC (HADDR)
//   fetch_req_out       : NONSEQ fetch request
//   instr_valid_out     : IF/ID holds a valid instruction
//   flush_out           : kill IF/ID and ID/EX this cycle
//   misaligned_exc_out  : request instruction-address-misaligned trap
//   stall_cnt_out       : saturating count of cycles spent waiting on the bus
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   ahb_ready_in,
  input  logic                   stall_in,
  input  logic                   branch_taken_in,
  input  logic                   misaligned_instr_in,
  input  logic                   trap_taken_in,
  input  logic                   mret_in,
  input  logic [31:0]            pc_mux_in,
  output logic [1:0]             pc_src_out,
  output logic [31:0]            pc_out,
  output logic                   fetch_req_out,
  output logic                   instr_valid_out,
  output logic                   flush_out,
  output logic                   misaligned_exc_out,
  output logic [STALL_CNT_W-1:0] stall_cnt_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;

  pc_src_e      pc_src;
  logic         flush;
  logic         misaligned_exc;
  logic         fetch_req;
  logic         advance;

  assign advance = ahb_ready_in & ~stall_in;

  // pc_src/flush/misaligned_exc must be combinational: the datapath returns
  // pc_mux_in for the selected source within the same cycle.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    valid_d        = 1'b0;
    pc_src         = PcSrcNext;
    flush          = 1'b0;
    misaligned_exc = 1'b0;
    fetch_req      = 1'b0;

    unique case (state_q)
      StBoot: begin
        pc_src  = PcSrcBoot;
        pc_d    = align_pc(pc_mux_in);
        state_d = StRun;
      end

      StRun, StWait: begin
        fetch_req = 1'b1;
        if (trap_taken_in) begin
          // Trap and MRET redirect even while decode is stalled.
          pc_src  = PcSrcTrap;
          pc_d    = align_pc(pc_mux_in);
          flush   = 1'b1;
          state_d = StRun;
        end else if (mret_in) begin
          pc_src  = PcSrcEpc;
          pc_d    = align_pc(pc_mux_in);
          flush   = 1'b1;
          state_d = StRun;
        end else if (branch_taken_in && misaligned_instr_in) begin
          // Never load the bad target; park until the CSR unit takes the trap.
          misaligned_exc = 1'b1;
          flush          = 1'b1;
          state_d        = StExcWait;
        end else if (branch_taken_in && advance) begin
          pc_d    = align_pc(pc_mux_in);
          flush   = 1'b1;
          state_d = StRun;
        end else begin
          // A stalled but ready bus still accepts the re-fetch of the same PC.
          valid_d = ahb_ready_in;
          if (advance) begin
            pc_d = align_pc(pc_mux_in);
          end
          state_d = ahb_ready_in ? StRun : StWait;
        end
      end

      StExcWait: begin
        if (trap_taken_in) begin
          pc_src  = PcSrcTrap;
          pc_d    = align_pc(pc_mux_in);
          flush   = 1'b1;
          state_d = StRun;
        end
      end

      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StBoot;
      pc_q    <= align_pc(BOOT_ADDRESS);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  sat_counter #(
    .Width (STALL_CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .inc_i   (state_q == StWait),
    .count_o (stall_cnt_out)
  );

  assign pc_src_out         = pc_src;
  assign pc_out             = pc_q;
  assign fetch_req_out      = fetch_req;
  assign instr_valid_out    = valid_q;
  assign flush_out          = flush;
  assign misaligned_exc_out = misaligned_exc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural model predicts each cycle's
// outputs, the stimulus pushes them, a monitor pops and compares.
module tb_fetch_ctrl;

  localparam logic [31:0] BootAddr = 32'h0000_0000;
  localparam int unsigned CntW     = 4;
  localparam int unsigned CntMax   = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst_in;
  logic            ahb_ready_in;
  logic            stall_in;
  logic            branch_taken_in;
  logic            misaligned_instr_in;
  logic            trap_taken_in;
  logic            mret_in;
  logic [31:0]     pc_mux_in;
  logic [1:0]      pc_src_out;
  logic [31:0]     pc_out;
  logic            fetch_req_out;
  logic            instr_valid_out;
  logic            flush_out;
  logic            misaligned_exc_out;
  logic [CntW-1:0] stall_cnt_out;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .BOOT_ADDRESS (BootAddr),
    .STALL_CNT_W  (CntW)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst_in),
    .ahb_ready_in        (ahb_ready_in),
    .stall_in            (stall_in),
    .branch_taken_in     (branch_taken_in),
    .misaligned_instr_in (misaligned_instr_in),
    .trap_taken_in       (trap_taken_in),
    .mret_in             (mret_in),
    .pc_mux_in           (pc_mux_in),
    .pc_src_out          (pc_src_out),
    .pc_out              (pc_out),
    .fetch_req_out       (fetch_req_out),
    .instr_valid_out     (instr_valid_out),
    .flush_out           (flush_out),
    .misaligned_exc_out  (misaligned_exc_out),
    .stall_cnt_out       (stall_cnt_out)
  );

  typedef struct {
    logic [1:0]  src;
    logic        flush;
    logic        exc;
    logic        freq;
    logic [31:0] pc;
    logic        valid;
    int unsigned cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: which phase the fetcher is in, its PC, and derived counters.
  typedef enum {MBoot, MRun, MWait, MExc} mode_e;
  mode_e       m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  int unsigned m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = MBoot;
    m_pc    = BootAddr;
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  // One bus cycle: drive inputs at the falling edge and predict the response.
  task automatic cycle(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt,
                       input logic trp, input logic mrt, input logic [31:0] epc,
                       input logic [31:0] tvec);
    exp_t        e;
    logic        mis, adv, load;
    logic [31:0] mux;
    mode_e       n_mode;
    logic        n_valid;
    @(negedge clk);
    mis     = br && tgt[1];
    adv     = rdy && !stl;
    e.freq  = (m_mode == MRun) || (m_mode == MWait);
    e.src   = 2'b11;
    e.flush = 1'b0;
    e.exc   = 1'b0;
    n_mode  = m_mode;
    n_valid = 1'b0;
    load    = 1'b0;
    if (m_mode == MBoot) begin
      e.src = 2'b00; load = 1'b1; n_mode = MRun;
    end else if (trp) begin
      e.src = 2'b10; e.flush = 1'b1; load = 1'b1; n_mode = MRun;
    end else if (m_mode == MExc) begin
      n_mode = MExc;
    end else if (mrt) begin
      e.src = 2'b01; e.flush = 1'b1; load = 1'b1; n_mode = MRun;
    end else if (mis) begin
      e.exc = 1'b1; e.flush = 1'b1; n_mode = MExc;
    end else if (br && adv) begin
      e.flush = 1'b1; load = 1'b1; n_mode = MRun;
    end else begin
      n_valid = rdy; load = adv; n_mode = rdy ? MRun : MWait;
    end
    case (e.src)
      2'b00:   mux = BootAddr;
      2'b01:   mux = epc;
      2'b10:   mux = tvec;
      default: mux = br ? tgt : m_pc + 32'd4;
    endcase
    if (m_mode == MWait && m_cnt < CntMax) m_cnt++;
    if (load) m_pc = mux & 32'hffff_fffc;
    m_mode  = n_mode;
    m_valid = n_valid;
    e.pc    = m_pc;
    e.valid = m_valid;
    e.cnt   = m_cnt;
    ahb_ready_in        = rdy;
    stall_in            = stl;
    branch_taken_in     = br;
    misaligned_instr_in = mis;
    trap_taken_in       = trp;
    mret_in             = mrt;
    pc_mux_in           = mux;
    sb_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc_out, BootAddr);
    check({tag, "_stall_cnt"}, 32'(stall_cnt_out), 32'd0);
    check({tag, "_fetch_req"}, 32'(fetch_req_out), 32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid_out), 32'd0);
    check({tag, "_flush"}, 32'(flush_out), 32'd0);
    check({tag, "_misaligned_exc"}, 32'(misaligned_exc_out), 32'd0);
    check({tag, "_pc_src"}, 32'(pc_src_out), 32'd0);
  endtask

  // Monitor: combinational outputs sampled mid-cycle, registered ones after the edge.
  initial begin : monitor
    exp_t       e;
    logic [1:0] s;
    logic       f, x, r;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() != 0) begin
        s = pc_src_out;
        f = flush_out;
        x = misaligned_exc_out;
        r = fetch_req_out;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("pc_src", 32'(s), 32'(e.src));
        check("flush", 32'(f), 32'(e.flush));
        check("misaligned_exc", 32'(x), 32'(e.exc));
        check("fetch_req", 32'(r), 32'(e.freq));
        check("pc", pc_out, e.pc);
        check("instr_valid", 32'(instr_valid_out), 32'(e.valid));
        check("stall_cnt", 32'(stall_cnt_out), e.cnt);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic        rdy, stl, br, trp, mrt;
    logic [31:0] tgt, epc, tvec;
    rst_in = 1'b1;
    ahb_ready_in = 1'b0; stall_in = 1'b0; branch_taken_in = 1'b0;
    misaligned_instr_in = 1'b0; trap_taken_in = 1'b0; mret_in = 1'b0;
    pc_mux_in = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #1;
    rst_in = 1'b0;

    // Boot then sequential fetch: 0, 4, 8, 12.
    run(4);
    after_edge();
    check("seq_pc_12", pc_out, 32'h0000_000c);
    run(1);

    // Bus not ready for three cycles at 0x10.
    wait_cyc(3);
    run(1);
    after_edge();
    check("wait_resume_pc", pc_out, 32'h0000_0014);
    check("wait_stall_cnt", 32'(stall_cnt_out), 32'd3);

    // Aligned taken branch.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'd0, 32'd0);
    after_edge();
    check("branch_pc", pc_out, 32'h0000_0200);
    run(1);

    // Misaligned branch parks until the trap is taken.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0202, 1'b0, 1'b0, 32'd0, 32'd0);
    run(2);
    after_edge();
    check("exc_wait_pc_held", pc_out, 32'h0000_0204);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'h0000_0100);
    after_edge();
    check("trap_exit_pc", pc_out, 32'h0000_0100);

    // Trap and misaligned branch together while stalled: trap wins.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0302, 1'b1, 1'b0, 32'd0, 32'h0000_0180);
    after_edge();
    check("trap_over_branch_pc", pc_out, 32'h0000_0180);

    // MRET with an unaligned EPC, then stall re-fetch.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0042, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    after_edge();
    check("stall_pc_held", pc_out, 32'h0000_0040);

    // Long bus wait saturates the counter.
    wait_cyc(20);
    run(1);
    after_edge();
    check("stall_cnt_saturated", 32'(stall_cnt_out), CntMax);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rdy  = $urandom_range(0, 9) != 0;
      stl  = $urandom_range(0, 6) == 0;
      br   = $urandom_range(0, 7) == 0;
      tgt  = $urandom;
      trp  = (m_mode == MExc) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      mrt  = $urandom_range(0, 19) == 0;
      epc  = $urandom;
      tvec = $urandom;
      cycle(rdy, stl, br, tgt, trp, mrt, epc, tvec);
    end

    // Asynchronous reset in the middle of a bus wait.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'h0000_0500);
    wait_cyc(3);
    after_edge();
    check("pre_reset_pc", pc_out, 32'h0000_0500);
    rst_in = 1'b1;
    trap_taken_in = 1'b1;
    branch_taken_in = 1'b1;
    misaligned_instr_in = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    after_edge();
    trap_taken_in = 1'b0;
    branch_taken_in = 1'b0;
    misaligned_instr_in = 1'b0;
    rst_in = 1'b0;
    run(5);
    after_edge();
    check("post_reset_pc", pc_out, 32'h0000_0010);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
